song_sequencer: RTL and testbench

- Upstream stage of BellController: walks a song stored in synchronous block RAM and presents one 11-bit bell instruction at a time on Instruction/newData.
- Keeps a small prefetch FIFO so the bell stage never waits on memory.
- Supports play/pause, restart, looping, and end-of-song detection.
- Song word format: bit 11 is the end marker; bits 10:0 are the BellController instruction (duration[10:9], play[8], noteA[7:4], noteB[3:0]).

---
 rtl/song_sequencer_if.sv | 21 ++
 rtl/song_sequencer.sv | 88 ++++++++
 tb/tb_song_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: song RAM read port plus the instruction hand-off to the bell stage.
interface song_sequencer_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic                  MemRd;
    logic [11:0]           MemData;
    logic [10:0]           Instruction;
    logic                  newData;
    logic                  Take;

    modport master (
        output MemAddr, MemRd, Instruction, newData,
        input  MemData, Take
    );

    modport slave (
        input  MemAddr, MemRd, Instruction, newData,
        output MemData, Take
    );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song in block RAM into a small prefetch FIFO and hands
// one bell instruction at a time to the consumer, with pause, restart and looping.
module song_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Play,
    input  logic             Restart,
    input  logic             Loop,
    song_sequencer_if.master bus,
    output logic             Done,
    output logic             Playing
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [10:0]           fifo [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW:0]           count, count_nx;
    logic [10:0]           last_q;
    logic                  in_flight, pushed, active, marker, wrap, issue, push, pop;

    assign active          = state == RUN || state == DRAIN;
    assign marker          = in_flight && bus.MemData[11];
    assign wrap            = marker && Loop && pushed;
    // A returning end marker also blocks this cycle's fetch, so nothing past it is ever read.
    assign issue           = state == RUN && Play && !marker &&
                             ({1'b0, count} + (PW+2)'(in_flight)) < (PW+2)'(FIFO_DEPTH);
    assign push            = in_flight && !bus.MemData[11] && !Restart;
    assign pop             = bus.Take && bus.newData && !Restart;
    assign count_nx        = count + (PW+1)'(push) - (PW+1)'(pop);
    assign bus.MemAddr     = ptr;
    assign bus.MemRd       = issue;
    assign bus.newData     = count != 0 && Play && active;
    assign bus.Instruction = count != 0 ? fifo[rd_ptr] : last_q;
    assign Done            = state == DONE;
    assign Playing         = active && Play;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = Play ? RUN : IDLE;
            RUN:     state_nx = (marker && !wrap) ? DRAIN : RUN;
            DRAIN:   state_nx = count_nx == 0 ? DONE : DRAIN;
            default: state_nx = DONE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            ptr       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_flight <= 1'b0;
            pushed    <= 1'b0;
            last_q    <= '0;
        end else if (Restart) begin
            state     <= IDLE;
            ptr       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_flight <= 1'b0;
            pushed    <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= wrap ? '0 : issue ? ptr + ADDR_WIDTH'(1) : ptr;
            rd_ptr    <= pop ? rd_ptr + PW'(1) : rd_ptr;
            wr_ptr    <= push ? wr_ptr + PW'(1) : wr_ptr;
            count     <= count_nx;
            in_flight <= issue;
            pushed    <= wrap ? 1'b0 : pushed | push;
            last_q    <= pop ? fifo[rd_ptr] : last_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (push)
            fifo[wr_ptr] <= bus.MemData[10:0];
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: table-driven songs, hand-written corner sequences and randomized
// songs checked against a stream-level model of what the bell stage should receive.
module tb_song_sequencer;
    logic Clock = 1'b0, nReset = 1'b0, Play = 1'b0, Restart = 1'b0, Loop = 1'b0;
    logic Done, Playing;

    song_sequencer_if #(.ADDR_WIDTH(10)) bus();

    song_sequencer #(.ADDR_WIDTH(10), .FIFO_DEPTH(4)) dut (
        .Clock(Clock), .nReset(nReset), .Play(Play), .Restart(Restart), .Loop(Loop),
        .bus(bus), .Done(Done), .Playing(Playing)
    );

    always #5 Clock = ~Clock;

    logic [11:0] ram [1024];

    // Synchronous RAM; garbage on MemData when no read was issued.
    always @(posedge Clock) bus.MemData <= bus.MemRd ? ram[bus.MemAddr] : 12'($urandom);

    typedef struct {
        logic [11:0] w0, w1, w2;
        logic        loop;
        int          npops;
        logic [10:0] e0, e1, e2;
        logic        done;
    } vec_t;

    int          compared = 0, mismatched = 0;
    logic [10:0] popped [$];
    int          rd_count, nd_count, mk_count, max_addr;
    logic        prev_rd, chk_occ;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic t);
        Play = p;
        bus.Take = t;
        #2;
        if (prev_rd && bus.MemData[11]) mk_count++;
        prev_rd = bus.MemRd;
        if (bus.MemRd) begin
            rd_count++;
            if (int'(bus.MemAddr) > max_addr) max_addr = int'(bus.MemAddr);
        end
        if (bus.newData) nd_count++;
        if (t && bus.newData) popped.push_back(bus.Instruction);
        if (!p) chk("paused_idle", {30'd0, bus.newData, bus.MemRd}, 0);
        if (chk_occ) chk("no_overflow", int'(rd_count - mk_count - popped.size() <= 4), 1);
        @(posedge Clock);
        #1;
    endtask

    task automatic restart_song();
        Restart = 1'b1;
        Play = 1'b0;
        bus.Take = 1'b0;
        @(posedge Clock);
        #1;
        Restart = 1'b0;
        popped.delete();
        rd_count = 0; nd_count = 0; mk_count = 0; max_addr = 0; prev_rd = 1'b0;
    endtask

    task automatic fill_garbage();
        for (int i = 0; i < 1024; i++) ram[i] = {1'b0, 11'($urandom)};
    endtask

    task automatic load_ramp(); // ten-word song 0x010.. then end marker
        fill_garbage();
        for (int i = 0; i < 10; i++) ram[i] = 12'(16 + i);
        ram[10] = 12'h800;
    endtask

    initial begin
        vec_t vt [6];
        vt[0] = '{12'h105, 12'h242, 12'h800, 1'b0,  2, 11'h105, 11'h242, 11'h000, 1'b1};
        vt[1] = '{12'h105, 12'h800, 12'h333, 1'b1, -1, 11'h105, 11'h105, 11'h105, 1'b0};
        vt[2] = '{12'h800, 12'h111, 12'h222, 1'b1,  0, 11'h000, 11'h000, 11'h000, 1'b1};
        vt[3] = '{12'h800, 12'h111, 12'h222, 1'b0,  0, 11'h000, 11'h000, 11'h000, 1'b1};
        vt[4] = '{12'h7FF, 12'h001, 12'h800, 1'b0,  2, 11'h7FF, 11'h001, 11'h000, 1'b1};
        vt[5] = '{12'h123, 12'h456, 12'h800, 1'b1, -1, 11'h123, 11'h456, 11'h123, 1'b0};
        bus.Take = 1'b0;
        chk_occ = 1'b0;
        prev_rd = 1'b0;
        fill_garbage();

        #1;
        chk("rst_outputs", {bus.MemAddr, bus.MemRd, bus.Instruction, bus.newData, Done, Playing}, 0);
        @(posedge Clock);
        #1;
        nReset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            logic [10:0] e [3];
            fill_garbage();
            ram[0] = vt[v].w0; ram[1] = vt[v].w1; ram[2] = vt[v].w2;
            e[0] = vt[v].e0; e[1] = vt[v].e1; e[2] = vt[v].e2;
            restart_song();
            Loop = vt[v].loop;
            for (int c = 0; c < 60; c++) step(1'b1, c % 3 == 2);
            for (int j = 0; j < 3; j++)
                if (vt[v].npops < 0 || j < vt[v].npops)
                    chk($sformatf("vec%0d_pop%0d", v, j), popped.size() > j ? int'(popped[j]) : -1, int'(e[j]));
            if (vt[v].npops >= 0) chk($sformatf("vec%0d_npops", v), popped.size(), vt[v].npops);
            chk($sformatf("vec%0d_done", v), Done, vt[v].done);
            if (v == 0) chk("vec0_max_addr_le3", int'(max_addr <= 3), 1);
        end

        // Reset mid-run with entries queued, then a clean restart of fetching at address 0
        load_ramp();
        Loop = 1'b0;
        restart_song();
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
        #2;
        nReset = 1'b0;
        #1;
        chk("async_rst_outputs", {bus.MemAddr, bus.MemRd, bus.Instruction, bus.newData, Done, Playing}, 0);
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        step(1'b1, 1'b0);
        chk("post_rst_fetch", {bus.MemRd, 22'(bus.MemAddr)}, {1'b1, 22'd0});

        // Take held low on a 2-word song: three reads, two queued, then exact Done timing
        fill_garbage();
        ram[0] = 12'h105; ram[1] = 12'h242; ram[2] = 12'h800;
        restart_song();
        for (int c = 0; c < 20; c++) step(1'b1, 1'b0);
        chk("short_reads", rd_count, 3);
        step(1'b1, 1'b1);
        chk("short_done_before_last", Done, 0);
        step(1'b1, 1'b1);
        chk("short_done_after_last", Done, 1);
        chk("short_nd_after_last", bus.newData, 0);
        chk("short_hold_instr", bus.Instruction, 11'h242);
        chk("short_pops", popped.size() == 2 ? {popped[0], popped[1]} : 0, {11'h105, 11'h242});

        // Saturation: ten-word song with no consumer stops after four reads
        load_ramp();
        restart_song();
        for (int c = 0; c < 30; c++) step(1'b1, 1'b0);
        chk("sat_reads", rd_count, 4);
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
        chk("sat_reads_later", rd_count, 4);
        for (int c = 0; c < 40; c++) step(1'b1, 1'b1);
        chk("sat_npops", popped.size(), 10);
        for (int j = 0; j < 10 && j < popped.size(); j++) chk($sformatf("sat_pop%0d", j), popped[j], 16 + j);
        chk("sat_done", Done, 1);

        // Empty song with Loop=1 reaches DONE within 4 cycles
        fill_garbage();
        ram[0] = 12'h800;
        Loop = 1'b1;
        restart_song();
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
        chk("empty_loop_done", Done, 1);
        Loop = 1'b0;

        // Pause for 20 cycles with two entries queued, then resume on the same head
        fill_garbage();
        ram[0] = 12'h105; ram[1] = 12'h242; ram[2] = 12'h800;
        restart_song();
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
        rd_count = 0; nd_count = 0;
        for (int c = 0; c < 20; c++) step(1'b0, 1'b1);
        chk("pause_reads", rd_count, 0);
        chk("pause_newdata", nd_count, 0);
        chk("pause_pops", popped.size(), 0);
        chk("pause_playing", Playing, 0);
        Play = 1'b1;
        #1;
        chk("resume_head", {bus.newData, bus.Instruction}, {1'b1, 11'h105});
        for (int c = 0; c < 6; c++) step(1'b1, 1'b1);
        chk("resume_npops", popped.size(), 2);
        chk("resume_done", Done, 1);

        // Restart in the same cycle as Take and a returning read
        load_ramp();
        restart_song();
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
        Play = 1'b1; bus.Take = 1'b1; Restart = 1'b1;
        #2;
        chk("collide_pre", {bus.newData, prev_rd}, 2'b11);
        @(posedge Clock);
        #1;
        Restart = 1'b0;
        bus.Take = 1'b0;
        #1;
        chk("collide_post", {bus.newData, Playing, Done, bus.MemRd}, 0);
        popped.delete();
        for (int c = 0; c < 8; c++) step(1'b1, 1'b1);
        chk("collide_first", popped.size() > 1 ? {popped[0], popped[1]} : 0, {11'h010, 11'h011});

        // Randomized songs against a stream model
        chk_occ = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int          len;
            logic        lp;
            logic [10:0] song [$];
            fill_garbage();
            len = $urandom_range(0, 10);
            lp = 1'($urandom);
            song.delete();
            for (int i = 0; i < len; i++) begin
                song.push_back(11'($urandom));
                ram[i] = {1'b0, song[i]};
            end
            ram[len] = {1'b1, 11'($urandom)};
            Loop = lp;
            restart_song();
            for (int c = 0; c < 150; c++) step($urandom_range(0, 4) != 0, 1'($urandom));
            for (int c = 0; c < 60; c++) step(1'b1, 1'b1);
            for (int k = 0; k < popped.size(); k++)
                if (len > 0 && (lp || k < len))
                    chk($sformatf("rnd%0d_pop%0d", it, k), popped[k], song[k % len]);
            if (!lp || len == 0) chk($sformatf("rnd%0d_npops", it), popped.size(), len);
            chk($sformatf("rnd%0d_done", it), Done, int'(!lp || len == 0));
        end
        chk_occ = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
